// File: rtl/arb_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_queue
// Brief    : N per-channel FIFOs feeding an external arbiter; pops on legal grant.
// Revision : 1.0
// ============================================================================
module arb_req_queue #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         push_valid,
    input  logic [N*W-1:0]       push_data,
    output logic [N-1:0]         push_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         grant,
    input  logic                 valid_grant,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 grant_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(N);
    localparam logic [N-1:0]  ONE_N  = N'(1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [W-1:0]  mem_q  [N][DEPTH];
    logic [AW-1:0] wptr_q [N];
    logic [AW-1:0] wptr_d [N];
    logic [AW-1:0] rptr_q [N];
    logic [AW-1:0] rptr_d [N];
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_src_q,   out_src_d;
    logic          grant_err_q, grant_err_d;

    logic [N-1:0]  push_fire;
    logic [N-1:0]  pop_fire;
    logic [SW-1:0] grant_idx;
    logic          grant_onehot;
    logic          grant_legal;

    // Status comes only from registered occupancy, so a same-cycle pop never frees a full slot.
    always_comb begin
        push_ready = '0;
        req        = '0;
        for (int i = 0; i < N; i++) begin
            push_ready[i] = (cnt_q[i] != FULL_C);
            req[i]        = (cnt_q[i] != '0);
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = SW'(i);
        end
        grant_onehot = (grant != '0) && ((grant & (grant - ONE_N)) == '0);
        grant_legal  = valid_grant && grant_onehot && ((grant & req) != '0);
        push_fire    = push_valid & push_ready;
        pop_fire     = grant_legal ? grant : '0;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            if (push_fire[i]) wptr_d[i] = wptr_q[i] + AW'(1);
            if (pop_fire[i])  rptr_d[i] = rptr_q[i] + AW'(1);
            cnt_d[i] = cnt_q[i] + CW'(push_fire[i]) - CW'(pop_fire[i]);
        end
    end

    always_comb begin
        out_valid_d = grant_legal;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        grant_err_d = grant_err_q | (valid_grant & ~grant_legal);
        if (grant_legal) begin
            out_data_d = mem_q[grant_idx][rptr_q[grant_idx]];
            out_src_d  = grant_idx;
        end
    end

    // Storage needs no reset: cleared pointers make every stale entry unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_fire[i]) mem_q[i][wptr_q[i]] <= push_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign grant_err = grant_err_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_req_queue
// Brief    : Directed self-checking bench for arb_req_queue (N=4, W=8, DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_arb_req_queue;

    logic        clk;
    logic        reset;
    logic [3:0]  push_valid;
    logic [31:0] push_data;
    logic [3:0]  push_ready;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        valid_grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        grant_err;

    int n_vec = 0;
    int n_err = 0;

    arb_req_queue #(.N(4), .W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .req         (req),
        .grant       (grant),
        .valid_grant (valid_grant),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .grant_err   (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid  = '0;
        push_data   = '0;
        grant       = '0;
        valid_grant = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (req !== 4'b0000) begin n_err++; $display("FAIL rst_req: got %b want 0000", req); end
        n_vec++; if (push_ready !== 4'b1111) begin n_err++; $display("FAIL rst_ready: got %b want 1111", push_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00 || out_src !== 2'd0) begin n_err++; $display("FAIL rst_out: got data %h src %0d want 00/0", out_data, out_src); end
        n_vec++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", grant_err); end
    endtask

    task automatic test_single();
        push_valid = 4'b0001; push_data = 32'h0000_00A1;
        tick(); idle();
        n_vec++; if (req !== 4'b0001) begin n_err++; $display("FAIL single_req: got %b want 0001", req); end
        grant = 4'b0001; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_src !== 2'd0) begin
            n_err++; $display("FAIL single_out: got v%b %h src%0d want v1 a1 src0", out_valid, out_data, out_src); end
        n_vec++; if (req !== 4'b0000) begin n_err++; $display("FAIL single_req_after: got %b want 0000", req); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_data !== 8'hA1 || out_src !== 2'd0) begin
            n_err++; $display("FAIL single_hold: got v%b %h src%0d want v0 a1 src0", out_valid, out_data, out_src); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            push_valid = 4'b1000; push_data = {8'(8'h10 + k), 24'h0};
            tick();
        end
        idle();
        n_vec++; if (push_ready !== 4'b0111) begin n_err++; $display("FAIL full_ready: got %b want 0111", push_ready); end
        push_valid = 4'b1000; push_data = {8'h14, 24'h0};
        tick(); idle();
        n_vec++; if (push_ready !== 4'b0111) begin n_err++; $display("FAIL full_drop_ready: got %b want 0111", push_ready); end
        for (int k = 0; k < 4; k++) begin
            grant = 4'b1000; valid_grant = 1'b1;
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k) || out_src !== 2'd3) begin
                n_err++; $display("FAIL full_pop%0d: got v%b %h src%0d want v1 %h src3", k, out_valid, out_data, out_src, 8'(8'h10 + k)); end
        end
        idle();
        n_vec++; if (push_ready !== 4'b1111 || req !== 4'b0000) begin
            n_err++; $display("FAIL full_drained: got ready %b req %b want 1111/0000", push_ready, req); end
    endtask

    task automatic test_simul();
        push_valid = 4'b0010; push_data = 32'h0000_3300; tick();
        push_data = 32'h0000_4400; tick();
        push_data = 32'h0000_5500; grant = 4'b0010; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_src !== 2'd1) begin
            n_err++; $display("FAIL simul_pop0: got v%b %h src%0d want v1 33 src1", out_valid, out_data, out_src); end
        n_vec++; if (push_ready !== 4'b1111 || req !== 4'b0010) begin
            n_err++; $display("FAIL simul_state: got ready %b req %b want 1111/0010", push_ready, req); end
        grant = 4'b0010; valid_grant = 1'b1;
        tick();
        n_vec++; if (out_data !== 8'h44) begin n_err++; $display("FAIL simul_pop1: got %h want 44", out_data); end
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin n_err++; $display("FAIL simul_pop2: got v%b %h want v1 55", out_valid, out_data); end
        n_vec++; if (req !== 4'b0000) begin n_err++; $display("FAIL simul_empty: got %b want 0000", req); end
    endtask

    task automatic test_no_valid_grant();
        push_valid = 4'b0010; push_data = 32'h0000_6600;
        tick(); idle();
        grant = 4'b0001; valid_grant = 1'b0;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b0 || grant_err !== 1'b0 || req !== 4'b0010) begin
            n_err++; $display("FAIL novalid: got v%b err%b req %b want v0 err0 req 0010", out_valid, grant_err, req); end
    endtask

    task automatic test_bad_grant();
        grant = 4'b0100; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b0 || grant_err !== 1'b1 || req !== 4'b0010) begin
            n_err++; $display("FAIL bad_target: got v%b err%b req %b want v0 err1 req 0010", out_valid, grant_err, req); end
        grant = 4'b0110; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b0 || req !== 4'b0010) begin
            n_err++; $display("FAIL bad_multi: got v%b req %b want v0 req 0010", out_valid, req); end
        grant = 4'b0000; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b0 || grant_err !== 1'b1) begin
            n_err++; $display("FAIL bad_zero: got v%b err%b want v0 err1", out_valid, grant_err); end
        grant = 4'b0010; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h66 || grant_err !== 1'b1) begin
            n_err++; $display("FAIL bad_sticky: got v%b %h err%b want v1 66 err1", out_valid, out_data, grant_err); end
    endtask

    task automatic test_async_reset();
        push_valid = 4'b0101; push_data = 32'h0002_0001; tick();
        push_valid = 4'b0001; push_data = 32'h0000_0003; tick();
        idle();
        grant = 4'b0001; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (req !== 4'b0101 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL arst_pre: got req %b v%b want 0101 v1", req, out_valid); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (req !== 4'b0000 || push_ready !== 4'b1111 || out_valid !== 1'b0 || grant_err !== 1'b0) begin
            n_err++; $display("FAIL arst_now: got req %b ready %b v%b err%b want 0000 1111 v0 err0", req, push_ready, out_valid, grant_err); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        push_valid = 4'b0100; push_data = 32'h0099_0000;
        tick(); idle();
        n_vec++; if (req !== 4'b0100) begin n_err++; $display("FAIL arst_first_push: got %b want 0100", req); end
        grant = 4'b0100; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h99 || out_src !== 2'd2 || req !== 4'b0000) begin
            n_err++; $display("FAIL arst_flush: got v%b %h src%0d req %b want v1 99 src2 0000", out_valid, out_data, out_src, req); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] order [7];
        logic [7:0] expd  [7];
        order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        expd  = '{8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
        push_valid = 4'b1111; push_data = 32'hC3C2_C1C0;
        tick();
        n_vec++; if (req !== 4'b1111) begin n_err++; $display("FAIL b2b_req: got %b want 1111", req); end
        push_data = 32'hD3D2_D1D0; grant = 4'b0001; valid_grant = 1'b1;
        tick(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_src !== 2'd0 || push_ready !== 4'b1111) begin
            n_err++; $display("FAIL b2b_allpush: got v%b %h src%0d ready %b want v1 c0 src0 1111", out_valid, out_data, out_src, push_ready); end
        for (int k = 0; k < 7; k++) begin
            grant = 4'b0001 << order[k]; valid_grant = 1'b1;
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_data !== expd[k] || out_src !== order[k]) begin
                n_err++; $display("FAIL b2b_pop%0d: got v%b %h src%0d want v1 %h src%0d", k, out_valid, out_data, out_src, expd[k], order[k]); end
        end
        idle();
        n_vec++; if (req !== 4'b0000 || grant_err !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got req %b err%b want 0000 err0", req, grant_err); end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_no_valid_grant();
        test_bad_grant();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
